clock_div_multi: RTL and testbench
==================================

Name: clock_div_multi

Overview:
- Parametrised multi-channel successor to the team's fixed 0.01 s clock divider.
- Runs N independent counters from one system clock.
- Each channel has a runtime-programmable divisor, a per-channel enable, and a choice of square-wave (toggle) or single-cycle tick (pulse) output.
- Sits between the board oscillator and the timekeeping/display blocks, which consume either the divided clock_out or the tick strobe.

Parameters:
- N_CH, 4, number of divider channels (1..16).
- CNT_W, 32, divisor/counter width in bits.
- DIV_DEFAULT, 500000, reset divisor for every channel. At 50 MHz this gives a 0.01 s half-period.

Ports:
- clock_in  input  1  system clock; everything is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  N_CH  per-channel enable.
- mode  input  N_CH  per-channel output mode: 0 = toggle, 1 = pulse.
- sync_restart  input  1  single-cycle strobe that phase-aligns all channels.
- div_wr  input  1  divisor write strobe.
- div_ch  input  max(1,$clog2(N_CH))  channel addressed by div_wr.
- div_val  input  CNT_W  new divisor value.
- div_ack  output  1  one-cycle acknowledge of an accepted write.
- clock_out  output  N_CH  divided square wave (toggle mode).
- tick  output  N_CH  one-cycle strobe at terminal count (pulse mode).

Behaviour:
- Reset values (asynchronous on reset_n=0): all counters 0, active divisor = DIV_DEFAULT, pending flags 0, clock_out 0, tick 0, div_ack 0.
- Counting: while en[i]=1, cnt[i] runs 0..div[i]-1. Terminal count (TC) is cnt[i]==div[i]-1; cnt[i] returns to 0 on the following edge.
- Divisor of 0 or 1: treated as 1, so TC occurs every cycle.
- Toggle mode (mode[i]=0): clock_out[i] inverts on each TC edge, so the output period is 2*div cycles. tick[i] stays 0.
- Pulse mode (mode[i]=1): tick[i]=1 for exactly the one cycle following each TC edge, so the tick period is div cycles. clock_out[i] holds its last value.
- Mode change mid-count: takes effect at the next TC. The counter is not disturbed.
- en[i]=0: cnt[i] is held at 0 and tick[i]=0. clock_out[i] is forced to 0 on the next edge. On re-enable, counting starts from 0, so the first TC comes div cycles later.
- Divisor write, acceptance: with div_wr=1 and div_ch<N_CH, div_val is latched into pend[div_ch] and the pending flag is set. div_ack=1 on the next cycle.
- Divisor write, out-of-range channel: div_ch>=N_CH is ignored with no ack.
- Pending divisor apply: the pending value is copied into the active divisor at that channel's next TC, or on the next edge if the channel is disabled. The pending flag then clears.
- Write in the same cycle as a TC on that channel: the new value is applied at that TC.
- Second write before apply: overwrites pend and is acked again. The last value wins.
- sync_restart=1: all counters go to 0 and all clock_out go to 0 on the next edge. No tick is produced in that cycle. Pending divisors are applied immediately.
- sync_restart coincident with div_wr: the write is latched first, so the new value is applied by the restart.
- sync_restart coincident with a TC: the restart wins; no toggle and no tick.
- Latency: all outputs are registered, with a single cycle from the TC edge to the output change.
- Reset asserted mid-count: all state returns to reset values immediately. Counting resumes from 0 on the first edge after reset_n rises.

Optional Feature:
- Macro: CLKDIV_TICK_CNT_EN.
- When defined: adds output tick_cnt (N_CH*16 bits). Each 16-bit field counts TC events of its channel and wraps 0xFFFF->0. It clears on reset, sync_restart, or en[i]=0.
- When undefined: the port and its counters are absent. All other behaviour is identical.

Decomposition:
- Package clock_div_pkg holds:
  - MODE_TOGGLE=1'b0 and MODE_PULSE=1'b1;
  - the per-field width constant TICK_CNT_W=16;
  - a function computing the effective divisor, clamping 0 to 1.
- Sub-module clock_div_chan implements one channel (counter, active/pending divisor, toggle/pulse output, optional tick counter).
- The top level contains the write decode, the div_ack register, and a generate loop of N_CH instances.

Test Plan:
- Reset with DIV_DEFAULT overridden to 5, channel 0 in toggle mode, en=1 → clock_out[0] first rises 5 cycles after reset release, then period is 10 cycles.
- Channel 1 in pulse mode, write div_val=3 → div_ack high 1 cycle later; after the next TC, tick[1] is high every 3rd cycle for exactly 1 cycle.
- Write div_val=0 to channel 2 in pulse mode → tick[2] is high every cycle. Write ch=N_CH → no div_ack and no state change.
- Channel 0 with div=8, write 4 at cnt=2 → the current period completes at 8; the next TC comes after 4 cycles. A write coincident with TC uses the new value immediately.
- Channels 0 and 1 set to div 6 and 9, pulse sync_restart → both counters 0 and clock_out 0 next edge; first toggles at +6 and +9 cycles; no tick in the restart cycle.
- Deassert en[3] mid-count, then reassert after 7 cycles; separately pulse reset_n low mid-count → clock_out[3] goes 0 and counting restarts at 0. Reset returns all outputs to 0 asynchronously. With CLKDIV_TICK_CNT_EN, tick_cnt clears and wraps 0xFFFF→0.

Source files
------------

// File: rtl/clock_div_pkg.sv
// clock_div_pkg: mode encoding, tick-counter field width and divisor clamp shared by clock_div_multi.
// Optional per-channel TC counters are enabled with the CLKDIV_TICK_CNT_EN macro.
package clock_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int TICK_CNT_W = 16;
  localparam int MAX_CNT_W  = 64;

  // A divisor of 0 would never reach terminal count, so it runs as divide-by-1.
  function automatic logic [MAX_CNT_W-1:0] eff_div(input logic [MAX_CNT_W-1:0] div);
    return (div == '0) ? MAX_CNT_W'(1) : div;
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// clock_div_chan: one divider channel with active/pending divisor and toggle or pulse output.
// Defining CLKDIV_TICK_CNT_EN adds a wrapping 16-bit count of terminal-count events.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 500000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_restart,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_val,
  output logic             o_clk,
  output logic             o_tick
`ifdef CLKDIV_TICK_CNT_EN
  ,output logic [TICK_CNT_W-1:0] o_tick_cnt
`endif
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_div_eff;
  logic [CNT_W-1:0] w_new_div;
  logic             w_tc;
  logic             w_has_new;
  logic             w_apply;

  assign w_div_eff = CNT_W'(eff_div(MAX_CNT_W'(r_div)));
  assign w_tc      = i_en && (r_cnt == w_div_eff - CNT_W'(1));
  // A write landing on an apply edge bypasses pend so the newest value takes effect there.
  assign w_has_new = i_wr || r_pend_vld;
  assign w_new_div = i_wr ? i_wr_val : r_pend;
  assign w_apply   = i_restart || !i_en || w_tc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_div      <= CNT_W'(DIV_DEFAULT);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_clk      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      if (w_apply && w_has_new) begin
        r_div      <= w_new_div;
        r_pend_vld <= 1'b0;
      end else if (i_wr) begin
        r_pend     <= i_wr_val;
        r_pend_vld <= 1'b1;
      end

      if (i_restart || !i_en) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_tick <= w_tc && (i_mode == MODE_PULSE);
        if (w_tc) begin
          r_cnt <= '0;
          if (i_mode == MODE_TOGGLE) r_clk <= ~r_clk;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

`ifdef CLKDIV_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] r_tick_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (i_restart || !i_en) begin
      r_tick_cnt <= '0;
    end else if (w_tc) begin
      r_tick_cnt <= r_tick_cnt + TICK_CNT_W'(1);
    end
  end

  assign o_tick_cnt = r_tick_cnt;
`endif

endmodule

// File: rtl/clock_div_multi.sv
// clock_div_multi: N_CH independent programmable clock dividers with shared write port and restart.
// Defining CLKDIV_TICK_CNT_EN adds the tick_cnt output (16 bits per channel).
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 500000
) (
  input  logic                                       clock_in,
  input  logic                                       reset_n,
  input  logic [N_CH-1:0]                            en,
  input  logic [N_CH-1:0]                            mode,
  input  logic                                       sync_restart,
  input  logic                                       div_wr,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] div_ch,
  input  logic [CNT_W-1:0]                           div_val,
  output logic                                       div_ack,
  output logic [N_CH-1:0]                            clock_out,
  output logic [N_CH-1:0]                            tick
`ifdef CLKDIV_TICK_CNT_EN
  ,output logic [N_CH*TICK_CNT_W-1:0]                tick_cnt
`endif
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            w_wr_ok;
  logic [N_CH-1:0] w_wr;
  logic            r_ack;

  // Channel numbers beyond N_CH are representable when N_CH is not a power of two.
  assign w_wr_ok = div_wr && (32'(div_ch) < N_CH);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_ack <= 1'b0;
    else          r_ack <= w_wr_ok;
  end

  assign div_ack = r_ack;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_wr[i] = w_wr_ok && (div_ch == CH_W'(i));

    clock_div_chan #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .i_clk      (clock_in),
      .i_rst_n    (reset_n),
      .i_en       (en[i]),
      .i_mode     (mode[i]),
      .i_restart  (sync_restart),
      .i_wr       (w_wr[i]),
      .i_wr_val   (div_val),
      .o_clk      (clock_out[i]),
      .o_tick     (tick[i])
`ifdef CLKDIV_TICK_CNT_EN
      ,.o_tick_cnt (tick_cnt[i*TICK_CNT_W +: TICK_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: scoreboard bench; expected {div_ack, tick, clock_out} per edge comes from hand-derived event tables.
// Builds with or without CLKDIV_TICK_CNT_EN.
module tb_clock_div_multi;
  import clock_div_pkg::*;

  localparam int NC  = 5;
  localparam int CW  = 32;
  localparam int CHW = 3;
  localparam int OW  = 2 * NC + 1;

  logic          clock_in     = 1'b0;
  logic          reset_n      = 1'b1;
  logic [NC-1:0] en           = '0;
  logic [NC-1:0] mode         = '0;
  logic          sync_restart = 1'b0;
  logic          div_wr       = 1'b0;
  logic [CHW-1:0] div_ch      = '0;
  logic [CW-1:0] div_val      = '0;
  logic          div_ack;
  logic [NC-1:0] clock_out;
  logic [NC-1:0] tick;
`ifdef CLKDIV_TICK_CNT_EN
  logic [NC*TICK_CNT_W-1:0] tick_cnt;
`endif

  logic [OW-1:0] obs;
  assign obs = {div_ack, tick, clock_out};

  clock_div_multi #(
    .N_CH        (NC),
    .CNT_W       (CW),
    .DIV_DEFAULT (5)
  ) u_dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .en           (en),
    .mode         (mode),
    .sync_restart (sync_restart),
    .div_wr       (div_wr),
    .div_ch       (div_ch),
    .div_val      (div_val),
    .div_ack      (div_ack),
    .clock_out    (clock_out),
    .tick         (tick)
`ifdef CLKDIV_TICK_CNT_EN
    ,.tick_cnt    (tick_cnt)
`endif
  );

  initial forever #5 clock_in = ~clock_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { int k; int ch; logic [CW-1:0] val; } wr_t;
  typedef struct { int ch; int k; } ev_t;
  typedef struct { int k; logic [NC-1:0] en; } en_t;
  typedef struct { string tag; logic [OW-1:0] exp; } sb_t;

  wr_t wr_q[$];
  ev_t chg_q[$];
  ev_t tk_q[$];
  en_t en_q[$];
  int  rs_q[$];
  sb_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic add_wr(input int k, input int ch, input int unsigned val);
    wr_t w;
    w.k = k; w.ch = ch; w.val = CW'(val);
    wr_q.push_back(w);
  endtask

  task automatic add_en(input int k, input logic [NC-1:0] e);
    en_t x;
    x.k = k; x.en = e;
    en_q.push_back(x);
  endtask

  // Events at edges first, first+stride, ... up to last (clock_out changes or tick pulses).
  task automatic add_per(input bit is_tick, input int ch, input int first, input int stride, input int last);
    ev_t e;
    e.ch = ch;
    for (int k = first; k <= last; k += stride) begin
      e.k = k;
      if (is_tick) tk_q.push_back(e);
      else         chg_q.push_back(e);
    end
  endtask

  function automatic logic [OW-1:0] expected(input int k);
    logic [NC-1:0] co;
    logic [NC-1:0] tk;
    logic          ack;
    co = '0; tk = '0; ack = 1'b0;
    foreach (chg_q[j]) if (chg_q[j].k <= k) co[chg_q[j].ch] = ~co[chg_q[j].ch];
    foreach (tk_q[j])  if (tk_q[j].k == k)  tk[tk_q[j].ch] = 1'b1;
    foreach (wr_q[j])  if (wr_q[j].k == k && wr_q[j].ch < NC) ack = 1'b1;
    return {ack, tk, co};
  endfunction

  // Edge 1 is the first rising edge after reset release.
  task automatic run(input string tag, input int n);
    sb_t e;
    for (int k = 1; k <= n; k++) begin
      div_wr       = 1'b0;
      sync_restart = 1'b0;
      foreach (wr_q[j]) if (wr_q[j].k == k) begin
        div_wr  = 1'b1;
        div_ch  = CHW'(wr_q[j].ch);
        div_val = wr_q[j].val;
      end
      foreach (rs_q[j]) if (rs_q[j] == k) sync_restart = 1'b1;
      foreach (en_q[j]) if (en_q[j].k == k) en = en_q[j].en;
      e.tag = $sformatf("%s@%0d", tag, k);
      e.exp = expected(k);
      sb_q.push_back(e);
      step();
      e = sb_q.pop_front();
      check(e.tag, 64'(obs), 64'(e.exp));
    end
    div_wr       = 1'b0;
    sync_restart = 1'b0;
    wr_q.delete(); chg_q.delete(); tk_q.delete(); en_q.delete(); rs_q.delete();
  endtask

  task automatic do_reset(input logic [NC-1:0] m);
    reset_n      = 1'b0;
    en           = '0;
    mode         = m;
    div_wr       = 1'b0;
    sync_restart = 1'b0;
    step();
    step();
    check("reset_state", 64'(obs), 64'(0));
    reset_n = 1'b1;
  endtask

  initial begin
    #3;

    // Default divisor 5, toggle: first rise after 5 edges, period 10.
    do_reset(5'b00000);
    add_en(1, 5'b00001);
    add_per(0, 0, 5, 5, 20);
    run("toggle_default", 22);

    // Pulse channel 1, divisor 3 pending until the TC at edge 5.
    do_reset(5'b00010);
    add_en(1, 5'b00010);
    add_wr(1, 1, 3);
    add_per(1, 1, 5, 3, 20);
    run("pulse_div3", 21);

    // Divisor 0 on channel 2 ticks every cycle; channel 5 write is ignored.
    do_reset(5'b00101);
    add_en(1, 5'b00101);
    add_wr(1, 2, 0);
    add_wr(12, 5, 2);
    add_per(1, 0, 5, 5, 20);
    add_per(1, 2, 5, 1, 20);
    run("div0_and_oob", 20);

    // Divisor 8, write 4 at cnt=2, then a write coincident with TC.
    do_reset(5'b00000);
    add_en(1, 5'b00001);
    add_wr(1, 0, 8);
    add_wr(16, 0, 4);
    add_wr(29, 0, 2);
    add_per(0, 0, 5, 1, 5);
    add_per(0, 0, 13, 8, 21);
    add_per(0, 0, 25, 4, 29);
    add_per(0, 0, 31, 2, 35);
    run("div_rewrite", 36);

    // Restart at edge 10 coincides with a channel-2 TC and a write to channel 2.
    do_reset(5'b00100);
    add_en(1, 5'b00111);
    add_wr(1, 0, 6);
    add_wr(2, 1, 9);
    add_wr(10, 2, 2);
    rs_q.push_back(10);
    add_per(0, 0, 5, 5, 10);
    add_per(0, 0, 16, 6, 28);
    add_per(0, 1, 5, 5, 10);
    add_per(0, 1, 19, 9, 28);
    add_per(1, 2, 5, 1, 5);
    add_per(1, 2, 12, 2, 28);
    run("sync_restart", 28);

    // Disable channel 3 for 7 edges mid-count, then re-enable.
    do_reset(5'b00000);
    add_en(1, 5'b01000);
    add_en(8, 5'b00000);
    add_en(15, 5'b01000);
    add_per(0, 3, 5, 1, 5);
    add_per(0, 3, 8, 1, 8);
    add_per(0, 3, 19, 5, 29);
    run("en_gate", 31);

    // Reset mid-count clears outputs before any clock edge.
    reset_n = 1'b0;
    #2;
    check("async_reset", 64'(obs), 64'(0));
    do_reset(5'b00000);
    add_en(1, 5'b01000);
    add_per(0, 3, 5, 5, 10);
    run("after_reset", 12);

`ifdef CLKDIV_TICK_CNT_EN
    do_reset(5'b10000);
    add_en(1, 5'b10000);
    add_wr(1, 4, 1);
    add_per(1, 4, 5, 1, 10);
    run("tick_cnt_pre", 10);
    check("tick_cnt_count", 64'(tick_cnt[4*TICK_CNT_W +: TICK_CNT_W]), 64'(6));
    en = 5'b00000;
    step();
    check("tick_cnt_clear", 64'(tick_cnt[4*TICK_CNT_W +: TICK_CNT_W]), 64'(0));
    en = 5'b10000;
    repeat (65535) step();
    check("tick_cnt_max", 64'(tick_cnt[4*TICK_CNT_W +: TICK_CNT_W]), 64'(16'hFFFF));
    step();
    check("tick_cnt_wrap", 64'(tick_cnt[4*TICK_CNT_W +: TICK_CNT_W]), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
